// File: rtl/gpu_sram_pkg.sv
// Shared definitions for the GPU SRAM front-end: size defaults, FSM encoding and idle pin levels.
package gpu_sram_pkg;

  localparam int DW_DEF        = 8;
  localparam int AW_DEF        = 11;
  localparam int RSP_DEPTH_DEF = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic CEN_IDLE = 1'b1;
  localparam logic WEN_IDLE = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO for sram_ctrl: synchronous, first-word-fall-through, async active-high reset.
module sram_rsp_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/sram_ctrl.sv
// Byte-addressed valid/ready front-end for sram_wrapper with in-order read responses.
// Optional macro SRAM_CTRL_CLR_EN: zero every word of both banks after reset before accepting requests.
module sram_ctrl
  import gpu_sram_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [2*DW-1:0] rsp_rdata,
  output logic [DW-1:0] rsp_byte,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic          sram_sel,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [2*DW-1:0] sram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

`ifdef SRAM_CTRL_CLR_EN
  localparam state_t ST_RESET = ST_INIT;
  logic [AW:0] clr_q;
`else
  localparam state_t ST_RESET = ST_RUN;
`endif

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cred_q, cred_d;
  logic          acc, acc_rd, pop, push;
  logic          vld_p0, vld_p1;
  logic          sel_p0, sel_p1;
  logic [2*DW:0] fifo_rdata;

  assign acc       = req_valid & ready_q;
  assign acc_rd    = acc & ~req_we;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = vld_p1;
  assign req_ready = ready_q;

  // Credits count reads in flight plus buffered; a push only moves a read from pipe to FIFO.
  always_comb begin
    state_d = state_q;
`ifdef SRAM_CTRL_CLR_EN
    if (state_q == ST_INIT && (&clr_q)) state_d = ST_RUN;
`endif
    cred_d  = cred_q + {{(CW-1){1'b0}}, acc_rd} - {{(CW-1){1'b0}}, pop};
    ready_d = (state_d == ST_RUN) && (cred_d < CW'(RSP_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      ready_q <= 1'b0;
      cred_q  <= '0;
`ifdef SRAM_CTRL_CLR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cred_q  <= cred_d;
`ifdef SRAM_CTRL_CLR_EN
      if (state_q == ST_INIT) clr_q <= clr_q + 1'b1;
`endif
    end
  end

  // Issue stage: pins registered at the accepting edge, sampled by the SRAM one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_cen  <= CEN_IDLE;
      sram_wen  <= WEN_IDLE;
      sram_sel  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
`ifdef SRAM_CTRL_CLR_EN
      if (state_q == ST_INIT) begin
        sram_cen  <= 1'b0;
        sram_wen  <= 1'b0;
        sram_sel  <= clr_q[AW];
        sram_addr <= clr_q[AW-1:0];
        sram_din  <= '0;
      end else
`endif
      if (acc) begin
        sram_cen  <= 1'b0;
        sram_wen  <= ~req_we;
        sram_sel  <= req_addr[0];
        sram_addr <= req_addr[AW:1];
        if (req_we) sram_din <= req_wdata;
      end else begin
        sram_cen <= CEN_IDLE;
        sram_wen <= WEN_IDLE;
      end
    end
  end

  // Read pipeline p0 (pins driven) -> p1 (SRAM data valid) -> FIFO push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= acc_rd;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    sel_p0 <= req_addr[0];
    sel_p1 <= sel_p0;
  end

  sram_rsp_fifo #(
    .W     (2*DW + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({sel_p1, sram_dout}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (rsp_valid)
  );

  assign rsp_rdata = fifo_rdata[2*DW-1:0];
  assign rsp_byte  = fifo_rdata[2*DW] ? fifo_rdata[2*DW-1:DW] : fifo_rdata[DW-1:0];

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural two-bank synchronous SRAM.
module tb_sram_ctrl;

  localparam int DW = 8;
  localparam int AW = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_we;
  logic [AW:0]     req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid, rsp_ready;
  logic [2*DW-1:0] rsp_rdata;
  logic [DW-1:0]   rsp_byte;
  logic            sram_cen, sram_wen, sram_sel;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din;
  logic [2*DW-1:0] sram_dout;

  always #5 clk = ~clk;

  sram_ctrl #(.DW(DW), .AW(AW), .RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_byte  (rsp_byte),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_sel  (sram_sel),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Synchronous SRAM: byte write into the selected bank, full-word read
  logic [DW-1:0]   mem_lo [2**AW];
  logic [DW-1:0]   mem_hi [2**AW];
  logic [2*DW-1:0] dout_m;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        if (sram_sel) mem_hi[sram_addr] <= sram_din;
        else          mem_lo[sram_addr] <= sram_din;
      end else begin
        dout_m <= {mem_hi[sram_addr], mem_lo[sram_addr]};
      end
    end
  end
  assign sram_dout = dout_m;

  logic [DW-1:0]   ref_lo [2**AW];
  logic [DW-1:0]   ref_hi [2**AW];
  logic [3*DW-1:0] sb [$];
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    logic [AW-1:0] w;
    w = a[AW:1];
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      if (acc) begin
        if (we) begin
          if (a[0]) ref_hi[w] = d;
          else      ref_lo[w] = d;
        end else begin
          sb.push_back({ref_hi[w], ref_lo[w], a[0] ? ref_hi[w] : ref_lo[w]});
        end
      end
      tick();
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [3*DW-1:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e[3*DW-1:DW]);
        chk("rsp_byte", rsp_byte, e[DW-1:0]);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 2**AW; i++) begin
      ref_lo[i] = '0;
      ref_hi[i] = '0;
    end
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_wen", sram_wen, 1);
    chk("rst_sel", sram_sel, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef SRAM_CTRL_CLR_EN
    n = 0;
    for (int i = 0; i < 3 * 2**AW && !req_ready; i++) begin
      @(negedge clk);
      if (!req_ready) n++;
    end
    chk("init_cycles", n, 2 * 2**AW);
    tick();
    issue(1'b0, 12'h000, 8'h00);
    issue(1'b0, 12'hFFF, 8'h00);
    issue(1'b0, 12'h555, 8'h00);
    drain();
`else
    tick();
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    tick();
`endif

    // Writes to both banks of word 0, then a read with exact latency
    issue(1'b1, 12'h000, 8'hA5);
    chk("wr_cen", sram_cen, 0);
    chk("wr_wen", sram_wen, 0);
    chk("wr_sel", sram_sel, 0);
    chk("wr_din", sram_din, 8'hA5);
    issue(1'b1, 12'h001, 8'h3C);
    chk("wr_sel_hi", sram_sel, 1);
    issue(1'b0, 12'h000, 8'h00);
    chk("rd_cen", sram_cen, 0);
    chk("rd_wen", sram_wen, 1);
    @(negedge clk);
    chk("lat_e0", rsp_valid, 0);
    @(negedge clk);
    chk("lat_e1", rsp_valid, 0);
    @(negedge clk);
    chk("lat_e2", rsp_valid, 1);
    tick();
    drain();

    // High-byte read, then a high-bank write leaves the low bank intact
    issue(1'b0, 12'h001, 8'h00);
    issue(1'b1, 12'h001, 8'h5A);
    issue(1'b0, 12'h000, 8'h00);
    drain();
    chk("idle_cen", sram_cen, 1);
    chk("idle_wen", sram_wen, 1);

    // Top of the address space versus word 0
    issue(1'b1, 12'hFFF, 8'h77);
    issue(1'b1, 12'hFFE, 8'h11);
    issue(1'b0, 12'hFFF, 8'h00);
    issue(1'b0, 12'h000, 8'h00);
    issue(1'b0, 12'hFFE, 8'h00);
    drain();
    chk("hold_addr", sram_addr, 11'h7FF);

    // Response back-pressure: two reads fill the credits, the third waits
    rsp_ready = 1'b0;
    issue(1'b0, 12'h000, 8'h00);
    issue(1'b0, 12'h001, 8'h00);
    fork
      issue(1'b0, 12'hFFF, 8'h00);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("ready_full", req_ready, 0);
        end
        chk("stall_valid", rsp_valid, 1);
        chk("stall_head", rsp_byte, 8'hA5);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset with a read in flight: nothing may come back
    issue(1'b0, 12'h000, 8'h00);
    tick();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_cen", sram_cen, 1);
    chk("midrst_wen", sram_wen, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
